// File: rtl/phy_pkg.sv
// Shared types and constants for the PHY transmit arbiter: state encoding,
// the K28.5 control word and a counter-width helper.
package phy_pkg;

   localparam int          ANCHO_DEF     = 32;
   localparam logic [31:0] IDLE_WORD_DEF = 32'hBCBCBCBC;

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      IDLE   = 2'd1,
      GRANT0 = 2'd2,
      GRANT1 = 2'd3
   } state_t;

   // Bits needed to count from 0 up to and including n.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/phy_tx_arbiter_if.sv
// Requester and PHY-facing signals of the transmit arbiter, bundled as one interface.
interface phy_tx_arbiter_if #(parameter int ANCHO = phy_pkg::ANCHO_DEF);
   import phy_pkg::*;

   // Handshake: a word moves from requester g when valid_in_g and ready_out_g are
   // both high in the same cycle; ready_out_g is only raised while phy_ready is high.
   logic [ANCHO-1:0] data_in0;
   logic             valid_in0;
   logic             ready_out0;
   logic [ANCHO-1:0] data_in1;
   logic             valid_in1;
   logic             ready_out1;
   logic             phy_ready;
   logic [ANCHO-1:0] phy_input;
   logic             valid;
   logic             k_char;
   logic             selector;
   state_t           state_dbg;

   modport slave (
      input  data_in0, valid_in0, data_in1, valid_in1, phy_ready,
      output ready_out0, ready_out1, phy_input, valid, k_char, selector, state_dbg
   );

   modport master (
      output data_in0, valid_in0, data_in1, valid_in1, phy_ready,
      input  ready_out0, ready_out1, phy_input, valid, k_char, selector, state_dbg
   );

endinterface

// File: rtl/phy_tx_arbiter_arbitro_rr.sv
// Two-way round-robin decision with a bounded burst length.
// burst == 0 means nobody currently holds the link.
module arbitro_rr #(
   parameter int MAX_BURST = 4,
   parameter int BW        = phy_pkg::cnt_width(MAX_BURST)
) (
   input  logic          valid_in0,
   input  logic          valid_in1,
   input  logic          holder,
   input  logic          ultimo,
   input  logic [BW-1:0] burst,
   input  logic          avance,
   output logic          grant_valid,
   output logic          grant_id,
   output logic [BW-1:0] burst_next
);

   localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);
   localparam logic [BW-1:0] ONE   = BW'(1);

   logic h;
   logic v_h;
   logic v_o;

   // With no holder, treat the not-last-served requester as the incumbent so
   // round-robin order falls out of the same priority chain.
   assign h   = (burst == '0) ? ~ultimo : holder;
   assign v_h = h ? valid_in1 : valid_in0;
   assign v_o = h ? valid_in0 : valid_in1;

   always_comb begin
      grant_valid = 1'b0;
      grant_id    = h;
      burst_next  = burst;
      if (avance) begin
         if (v_h && (burst < MAX_B)) begin
            grant_valid = 1'b1;
            grant_id    = h;
            burst_next  = burst + ONE;
         end else if (v_o) begin
            grant_valid = 1'b1;
            grant_id    = ~h;
            burst_next  = ONE;
         end else if (v_h) begin
            grant_valid = 1'b1;
            grant_id    = h;
            burst_next  = ONE;
         end else begin
            burst_next  = '0;
         end
      end
   end

endmodule

// File: rtl/phy_tx_arbiter.sv
// PHY transmit controller: link-sync preamble after reset, then round-robin
// sharing of the PHY word stream between two requesters with idle fill.
module phy_tx_arbiter
   import phy_pkg::*;
#(
   parameter int               ANCHO     = ANCHO_DEF,
   parameter int               N_SYNC    = 4,
   parameter int               MAX_BURST = 4,
   parameter logic [ANCHO-1:0] IDLE_WORD = ANCHO'(IDLE_WORD_DEF)
) (
   input logic               clk_f,
   input logic               reset_L,
   phy_tx_arbiter_if.slave   bus
);

   localparam int             SW        = cnt_width(N_SYNC);
   localparam int             BW        = cnt_width(MAX_BURST);
   localparam logic [SW-1:0]  SYNC_LAST = SW'(N_SYNC - 1);
   localparam logic [SW-1:0]  SYNC_ONE  = SW'(1);

   state_t           state_q,     state_d;
   logic [SW-1:0]    sync_cnt_q,  sync_cnt_d;
   logic [BW-1:0]    burst_q,     burst_d;
   logic             ultimo_q,    ultimo_d;
   logic [ANCHO-1:0] phy_input_q, phy_input_d;
   logic             valid_q,     valid_d;
   logic             k_char_q,    k_char_d;
   logic             selector_q,  selector_d;

   logic          avance_arb;
   logic          grant_valid;
   logic          grant_id;
   logic [BW-1:0] burst_next;

   // Requesters are never considered while the preamble is still going out.
   assign avance_arb = bus.phy_ready && (state_q != SYNC);

   arbitro_rr #(
      .MAX_BURST (MAX_BURST),
      .BW        (BW)
   ) u_arbitro_rr (
      .valid_in0   (bus.valid_in0),
      .valid_in1   (bus.valid_in1),
      .holder      (selector_q),
      .ultimo      (ultimo_q),
      .burst       (burst_q),
      .avance      (avance_arb),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .burst_next  (burst_next)
   );

   always_ff @(posedge clk_f or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= SYNC;
         sync_cnt_q  <= '0;
         burst_q     <= '0;
         ultimo_q    <= 1'b1;
         phy_input_q <= '0;
         valid_q     <= 1'b0;
         k_char_q    <= 1'b0;
         selector_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_cnt_q  <= sync_cnt_d;
         burst_q     <= burst_d;
         ultimo_q    <= ultimo_d;
         phy_input_q <= phy_input_d;
         valid_q     <= valid_d;
         k_char_q    <= k_char_d;
         selector_q  <= selector_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sync_cnt_d  = sync_cnt_q;
      burst_d     = burst_q;
      ultimo_d    = ultimo_q;
      phy_input_d = phy_input_q;
      valid_d     = valid_q;
      k_char_d    = k_char_q;
      selector_d  = selector_q;
      if (bus.phy_ready) begin
         if (state_q == SYNC) begin
            phy_input_d = IDLE_WORD;
            k_char_d    = 1'b1;
            valid_d     = 1'b1;
            sync_cnt_d  = sync_cnt_q + SYNC_ONE;
            if (sync_cnt_q == SYNC_LAST) begin
               state_d = IDLE;
            end
         end else if (grant_valid) begin
            phy_input_d = grant_id ? bus.data_in1 : bus.data_in0;
            k_char_d    = 1'b0;
            valid_d     = 1'b1;
            selector_d  = grant_id;
            ultimo_d    = grant_id;
            state_d     = grant_id ? GRANT1 : GRANT0;
            burst_d     = burst_next;
         end else begin
            phy_input_d = IDLE_WORD;
            k_char_d    = 1'b1;
            valid_d     = 1'b1;
            state_d     = IDLE;
            burst_d     = burst_next;
         end
      end
   end

   always_comb begin
      bus.ready_out0 = grant_valid && !grant_id;
      bus.ready_out1 = grant_valid &&  grant_id;
      bus.phy_input  = phy_input_q;
      bus.valid      = valid_q;
      bus.k_char     = k_char_q;
      bus.selector   = selector_q;
      bus.state_dbg  = state_q;
   end

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Directed-then-random bench for phy_tx_arbiter, checked every cycle against a
// link-level model of preamble, round-robin bursts and idle fill.
module tb_phy_tx_arbiter;
   import phy_pkg::*;

   localparam int          N_SYNC    = 4;
   localparam int          MAX_BURST = 4;
   localparam logic [31:0] IDLE_W    = 32'hBCBCBCBC;

   logic clk_f   = 1'b0;
   logic reset_L = 1'b0;

   phy_tx_arbiter_if #(.ANCHO(32)) bus ();

   phy_tx_arbiter #(
      .ANCHO     (32),
      .N_SYNC    (N_SYNC),
      .MAX_BURST (MAX_BURST),
      .IDLE_WORD (IDLE_W)
   ) dut (
      .clk_f   (clk_f),
      .reset_L (reset_L),
      .bus     (bus)
   );

   always #5 clk_f = ~clk_f;

   int tests_run    = 0;
   int tests_failed = 0;

   // Stimulus sources
   bit       en0, en1, rdy;
   int       n0 = 1, n1 = 1;
   int       acc0, acc1;

   // Link-level model
   int          m_sync_left;
   bit          m_last;
   int          m_run;
   bit          m_owner;
   logic [31:0] e_phy;
   logic        e_valid, e_k, e_sel;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sync_left = N_SYNC;
      m_last      = 1'b1;
      m_run       = 0;
      m_owner     = 1'b0;
      e_phy       = '0;
      e_valid     = 1'b0;
      e_k         = 1'b0;
      e_sel       = 1'b0;
      exp_q.delete();
   endtask

   task automatic drive();
      bus.phy_ready = rdy;
      bus.valid_in0 = en0;
      bus.valid_in1 = en1;
      bus.data_in0  = 32'hA000_0000 + 32'(n0);
      bus.data_in1  = 32'hB000_0000 + 32'(n1);
   endtask

   // Who gets the link this cycle, from the arbitration rules.
   function automatic void predict(output bit gv, output bit gid);
      bit v[2];
      v[0] = en0;
      v[1] = en1;
      gv  = 1'b0;
      gid = 1'b0;
      if (!rdy || m_sync_left > 0) return;
      if (m_run == 0) begin
         if (v[0] && v[1]) begin gv = 1; gid = !m_last; end
         else if (v[0])    begin gv = 1; gid = 0; end
         else if (v[1])    begin gv = 1; gid = 1; end
      end else if (v[m_owner] && m_run < MAX_BURST) begin
         gv = 1; gid = m_owner;
      end else if (v[!m_owner]) begin
         gv = 1; gid = !m_owner;
      end else if (v[m_owner]) begin
         gv = 1; gid = m_owner;
      end
   endfunction

   task automatic cycle();
      bit gv, gid, loaded;
      drive();
      predict(gv, gid);
      #3;
      chk("ready_out0", 32'(bus.ready_out0), 32'(gv && !gid));
      chk("ready_out1", 32'(bus.ready_out1), 32'(gv && gid));
      @(posedge clk_f);
      loaded = 1'b0;
      if (rdy) begin
         if (m_sync_left > 0) begin
            e_phy = IDLE_W; e_k = 1; e_valid = 1;
            m_sync_left--;
         end else if (gv) begin
            e_phy   = gid ? bus.data_in1 : bus.data_in0;
            e_k     = 0;
            e_valid = 1;
            e_sel   = gid;
            exp_q.push_back(e_phy);
            m_run   = (m_run > 0 && gid == m_owner && m_run < MAX_BURST) ? m_run + 1 : 1;
            m_owner = gid;
            m_last  = gid;
            loaded  = 1'b1;
            if (gid) begin n1++; acc1++; end
            else     begin n0++; acc0++; end
         end else begin
            e_phy = IDLE_W; e_k = 1; e_valid = 1;
            m_run = 0;
         end
      end
      #1;
      chk("phy_input", bus.phy_input, e_phy);
      chk("valid",     32'(bus.valid),    32'(e_valid));
      chk("k_char",    32'(bus.k_char),   32'(e_k));
      chk("selector",  32'(bus.selector), 32'(e_sel));
      if (loaded && exp_q.size() > 0) chk("scoreboard", bus.phy_input, exp_q.pop_front());
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_phy_input"}, bus.phy_input, 32'h0);
      chk({tag, "_valid"},     32'(bus.valid),      32'h0);
      chk({tag, "_k_char"},    32'(bus.k_char),     32'h0);
      chk({tag, "_selector"},  32'(bus.selector),   32'h0);
      chk({tag, "_ready0"},    32'(bus.ready_out0), 32'h0);
      chk({tag, "_ready1"},    32'(bus.ready_out1), 32'h0);
      chk({tag, "_state"},     32'(bus.state_dbg),  32'(SYNC));
   endtask

   initial begin
      int guard;
      en0 = 0; en1 = 0; rdy = 0;
      drive();
      model_reset();
      #12;
      check_reset_outputs("reset");
      #10 reset_L = 1'b1;
      @(posedge clk_f); #1;

      // Preamble with both requesters pushing, then round-robin from requester 0.
      en0 = 1; en1 = 1; rdy = 1;
      for (int i = 0; i < 12; i++) cycle();

      // Lone requester 0 with three words, then idle fill.
      en1 = 0; en0 = 0;
      cycle();
      n0 = 1; acc0 = 0; guard = 0;
      en0 = 1;
      while (acc0 < 3 && guard < 20) begin cycle(); guard++; end
      chk("lone0_words_accepted", 32'(acc0), 32'd3);
      en0 = 0;
      for (int i = 0; i < 4; i++) cycle();

      // Both continuous: alternating bursts of MAX_BURST.
      en0 = 1; en1 = 1;
      for (int i = 0; i < 14; i++) cycle();

      // PHY stall mid-burst.
      rdy = 0;
      for (int i = 0; i < 3; i++) cycle();
      rdy = 1;
      for (int i = 0; i < 6; i++) cycle();

      // Lone requester 1 streams past MAX_BURST without gaps.
      en0 = 0; en1 = 1; acc1 = 0;
      for (int i = 0; i < 8; i++) cycle();
      chk("lone1_words_accepted", 32'(acc1), 32'd8);

      // Asynchronous reset between edges, mid-burst.
      en0 = 1; en1 = 1;
      for (int i = 0; i < 2; i++) cycle();
      #2 reset_L = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      rdy = 0;
      drive();
      @(posedge clk_f); #2;
      reset_L = 1'b1;
      @(posedge clk_f); #1;
      rdy = 1;
      for (int i = 0; i < 10; i++) cycle();

      // Random traffic, backpressure and valid drops.
      for (int i = 0; i < 400; i++) begin
         en0 = ($urandom_range(0, 3) != 0);
         en1 = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 4) != 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/phy_tx_arbiter.md
Name: phy_tx_arbiter

Overview:
Transmit-side controller that sequences and shares the 32-bit PHY input word stream between two requesters.
- After reset it emits a fixed link-sync preamble.
- It then round-robin arbitrates two valid/ready sources into the PHY, with a bounded burst length.
- It inserts idle control words whenever no source has data.
- It sits directly in front of the phy datapath, drives phy_input/valid, and honours backpressure from the PHY.

Parameters:
ANCHO, 32, data word width
N_SYNC, 4, number of sync words emitted after reset (>=1)
MAX_BURST, 4, maximum consecutive words granted to one requester while the other is waiting (>=1)
IDLE_WORD, 32'hBCBCBCBC, control word (4x COM K28.5) used for sync and idle

Ports:
clk_f  in  1  clock; all state updates on rising edge
reset_L  in  1  asynchronous, active-low reset
data_in0  in  ANCHO  requester 0 data
valid_in0  in  1  requester 0 has a word
ready_out0  out  1  requester 0 word accepted this cycle
data_in1  in  ANCHO  requester 1 data
valid_in1  in  1  requester 1 has a word
ready_out1  out  1  requester 1 word accepted this cycle
phy_ready  in  1  PHY accepts the word on phy_input this cycle
phy_input  out  ANCHO  word to PHY (registered)
valid  out  1  phy_input valid (registered)
k_char  out  1  1 = phy_input is a control word (sync/idle) (registered)
selector  out  1  source of current data word; holds last value during idle (registered)

Behaviour:
- Reset (reset_L=0, takes effect immediately, independent of clk_f):
  - phy_input=0, valid=0, k_char=0, selector=0.
  - state=SYNC, sync counter=0, burst counter=0, ultimo (last served)=1, so requester 0 wins first.
  - ready_out0/1 are 0 while state=SYNC.
- Advance condition: avance = phy_ready.
  - When phy_ready=0, every register holds and ready_out0=ready_out1=0.
  - No word is lost or duplicated.
- States:
  - SYNC: on each avance, load IDLE_WORD, k_char=1, valid=1, and increment the counter. The avance with counter==N_SYNC-1 transitions to IDLE. Requesters are never acknowledged in SYNC.
  - IDLE / GRANT0 / GRANT1: the state names the source of the word now on phy_input. On each avance, the arbitration decision (combinational, same cycle) selects g:
    - If the current holder h is still valid and burst<MAX_BURST: g=h.
    - Else, if the other requester is valid: g=other, burst=1.
    - Else, if h is valid: g=h and burst restarts at 1. A lone requester therefore streams continuously.
    - Else, from IDLE with both valid: g = requester != ultimo.
    - Else: no grant.
  - Grant g: ready_out_g=1 combinationally. Next edge loads phy_input=data_in_g, k_char=0, valid=1, selector=g, ultimo=g, state=GRANTg, burst++.
  - No grant: next edge loads IDLE_WORD, k_char=1, valid=1, selector unchanged, state=IDLE, burst=0.
- Latency: a word accepted on edge N (valid_in_g & ready_out_g) appears on phy_input after edge N, i.e. 1 cycle.
- Simultaneous events:
  - A requester dropping valid in the same cycle it would be granted yields no transfer to it.
  - At most one ready_out is high at any time.
- Burst counter width: ceil(log2(MAX_BURST+1)); never exceeds MAX_BURST.

Decomposition:
- Shared package phy_pkg holds:
  - state encoding (SYNC=2'd0, IDLE=2'd1, GRANT0=2'd2, GRANT1=2'd3);
  - IDLE_WORD;
  - the ANCHO default.
- One sub-module, arbitro_rr: two-way round-robin decision plus burst counter.
  - Inputs: valid_in0/1, holder, ultimo, burst, avance.
  - Outputs: grant_valid, grant_id, next burst.
- The top holds SYNC sequencing and the output registers.

Test Plan:
1. Release reset with phy_ready=1 and both valid_in=1 → 4 cycles of phy_input=BCBCBCBC, k_char=1, valid=1, with ready_out0/1=0. The 5th word is requester 0's data with selector=0.
2. Only requester 0 offers A0000001..A0000003 → each appears on phy_input exactly 1 cycle after its handshake with k_char=0. IDLE_WORD with k_char=1 follows; selector stays 0.
3. Both requesters continuously valid, MAX_BURST=4 → selector sequence 0,0,0,0,1,1,1,1,0,... with no idle words inserted.
4. phy_ready=0 for 3 cycles mid-burst → phy_input/valid/selector hold, ready_out0/1=0. Data resumes with the next sequential word, none dropped or repeated.
5. Only requester 1 valid for 6 words (MAX_BURST=4) → 6 consecutive words with selector=1, no idle gap.
6. reset_L driven low asynchronously between edges mid-burst → outputs are 0 before the next clk_f edge. After release, the full 4-word SYNC repeats and requester 0 is granted first.
